managed_activation_memory_banked: RTL and testbench

- Next-generation activation store: NUM_BANKS single-port activation banks with ping-pong (rotating) layer buffering.
- The control datapath reads the current layer's activations from the read bank and writes the next layer's results into the write bank.
- SPI host access goes through a ready/valid request channel. Control traffic has priority over SPI; SPI stalls on a bank conflict instead of corrupting data.
- Sits between the SPI command decoder and the network controller, in place of the single-bank activation memory.

---
 rtl/activation_memory_pkg.sv | 71 +++++++
 rtl/managed_activation_memory_banked_bank.sv | 57 +++++
 rtl/managed_activation_memory_banked.sv | 237 +++++++++++++++++++++++
 tb/tb_managed_activation_memory_banked.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_memory_pkg.sv
// activation_memory_pkg
// Shared definitions for the banked activation memory:
//   - default parameter values and the derived widths (ROW_W, BANK_W,
//     SLICES, SLICE_W) plus the functions that compute them, so the top
//     level can re-derive them for non-default parameter sets;
//   - SPI address field extraction ({bank, row, slice}, slice in the LSBs);
//   - parameter legality predicates used by elaboration-time checks.
package activation_memory_pkg;

    localparam int DEFAULT_ACTIVATION_WORD_BIT_WIDTH = 64;
    localparam int DEFAULT_ACTIVATION_ROWS           = 32;
    localparam int DEFAULT_NUM_BANKS                 = 2;
    localparam int DEFAULT_START_ADDRESS_BIT_WIDTH   = 14;
    localparam int DEFAULT_MESSAGE_BIT_WIDTH         = 32;

    // Width helpers never return 0 so that every derived vector stays legal.
    function automatic int row_w_of(input int rows);
        return (rows <= 2) ? 1 : $clog2(rows);
    endfunction

    function automatic int bank_w_of(input int num_banks);
        return (num_banks <= 2) ? 1 : $clog2(num_banks);
    endfunction

    function automatic int slices_of(input int word_w, input int msg_w);
        return word_w / msg_w;
    endfunction

    function automatic int slice_w_of(input int slices);
        return (slices <= 2) ? 1 : $clog2(slices);
    endfunction

    localparam int ROW_W   = row_w_of(DEFAULT_ACTIVATION_ROWS);
    localparam int BANK_W  = bank_w_of(DEFAULT_NUM_BANKS);
    localparam int SLICES  = slices_of(DEFAULT_ACTIVATION_WORD_BIT_WIDTH,
                                       DEFAULT_MESSAGE_BIT_WIDTH);
    localparam int SLICE_W = slice_w_of(SLICES);

    function automatic bit banks_legal(input int num_banks);
        return num_banks >= 2;
    endfunction

    function automatic bit widths_legal(input int word_w, input int msg_w);
        return (msg_w > 0) && (word_w >= msg_w) && ((word_w % msg_w) == 0);
    endfunction

    // Generic field extraction; callers cast the result down to the field width.
    function automatic int unsigned addr_field(input logic [63:0] addr,
                                               input int lsb, input int width);
        logic [63:0] field_mask;
        field_mask = (64'd1 << width) - 64'd1;
        return 32'((addr >> lsb) & field_mask);
    endfunction

    function automatic int unsigned addr_slice(input logic [63:0] addr,
                                               input int slice_w);
        return addr_field(addr, 0, slice_w);
    endfunction

    function automatic int unsigned addr_row(input logic [63:0] addr,
                                             input int slice_w, input int row_w);
        return addr_field(addr, slice_w, row_w);
    endfunction

    function automatic int unsigned addr_bank(input logic [63:0] addr,
                                              input int slice_w, input int row_w,
                                              input int bank_w);
        return addr_field(addr, slice_w + row_w, bank_w);
    endfunction

endpackage

// File: rtl/managed_activation_memory_banked_bank.sv
// activation_bank
// Single-port synchronous RAM with a per-bit write mask and 1-cycle read
// latency. Contents are not reset; only the read data register is.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (read register only)
//   power_down   suppresses every access while high
//   en, we       access enable, 1 = write / 0 = read
//   addr         row address
//   wdata, wmask write data and per-bit mask (1 = write this bit)
//   rdata        read data, valid the cycle after a read, held otherwise
module activation_bank
    import activation_memory_pkg::*;
#(
    parameter int WORD_W = DEFAULT_ACTIVATION_WORD_BIT_WIDTH,
    parameter int ROWS   = DEFAULT_ACTIVATION_ROWS,
    localparam int AW    = row_w_of(ROWS)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              power_down,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] wmask,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [ROWS];
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              do_read, do_write;

    // Power-down overrides any enable the arbiter produced.
    always_comb begin
        do_read  = en && !we && !power_down;
        do_write = en &&  we && !power_down;
        rdata_d  = do_read ? mem[addr] : rdata_q;
    end

    // Storage: masked read-modify-write of the addressed row, no reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/managed_activation_memory_banked.sv
// managed_activation_memory_banked
// NUM_BANKS single-port activation banks with rotating (ping-pong) layer
// buffering. Control reads hit read_bank and control writes hit write_bank;
// SPI requests go to any bank and are held off (ready low) whenever control
// uses the targeted bank in the same cycle.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   global_power_down      blocks all accesses, ready low, valids drop
//   spi_req_*/spi_write    SPI ready/valid request, address {bank,row,slice}
//   spi_rsp_valid/data_out SPI read response, 1 cycle after acceptance
//   ctrl_read_*            control read of read_bank, 1-cycle latency
//   ctrl_write_*/ctrl_mask masked control write to write_bank
//   layer_swap             advance the bank rotation
//   read_bank, write_bank  current rotation indices
module managed_activation_memory_banked
    import activation_memory_pkg::*;
#(
    parameter int ACTIVATION_WORD_BIT_WIDTH = DEFAULT_ACTIVATION_WORD_BIT_WIDTH,
    parameter int ACTIVATION_ROWS           = DEFAULT_ACTIVATION_ROWS,
    parameter int NUM_BANKS                 = DEFAULT_NUM_BANKS,
    parameter int START_ADDRESS_BIT_WIDTH   = DEFAULT_START_ADDRESS_BIT_WIDTH,
    parameter int MESSAGE_BIT_WIDTH         = DEFAULT_MESSAGE_BIT_WIDTH,
    localparam int ROW_W   = row_w_of(ACTIVATION_ROWS),
    localparam int BANK_W  = bank_w_of(NUM_BANKS),
    localparam int SLICES  = slices_of(ACTIVATION_WORD_BIT_WIDTH, MESSAGE_BIT_WIDTH),
    localparam int SLICE_W = slice_w_of(SLICES)
)(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 global_power_down,
    input  logic                                 spi_req_valid,
    output logic                                 spi_req_ready,
    input  logic                                 spi_write,
    input  logic [START_ADDRESS_BIT_WIDTH-1:0]   spi_address,
    input  logic [MESSAGE_BIT_WIDTH-1:0]         spi_data_in,
    output logic                                 spi_rsp_valid,
    output logic [MESSAGE_BIT_WIDTH-1:0]         spi_data_out,
    input  logic                                 ctrl_read_enable,
    input  logic [ROW_W-1:0]                     ctrl_read_address,
    output logic                                 ctrl_read_valid,
    output logic [ACTIVATION_WORD_BIT_WIDTH-1:0] ctrl_data_out,
    input  logic                                 ctrl_write_enable,
    input  logic [ROW_W-1:0]                     ctrl_write_address,
    input  logic [ACTIVATION_WORD_BIT_WIDTH-1:0] ctrl_data_in,
    input  logic [ACTIVATION_WORD_BIT_WIDTH-1:0] ctrl_mask,
    input  logic                                 layer_swap,
    output logic [BANK_W-1:0]                    read_bank,
    output logic [BANK_W-1:0]                    write_bank
);

    localparam int WORD_W = ACTIVATION_WORD_BIT_WIDTH;
    localparam int MSG_W  = MESSAGE_BIT_WIDTH;

    if (!banks_legal(NUM_BANKS)) begin : g_check_banks
        $error("NUM_BANKS must be at least 2");
    end
    if (!widths_legal(WORD_W, MSG_W)) begin : g_check_widths
        $error("ACTIVATION_WORD_BIT_WIDTH must be a multiple of MESSAGE_BIT_WIDTH");
    end

    logic [BANK_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BANK_W-1:0]  wr_ptr;

    logic [BANK_W-1:0]  spi_bank;
    logic [ROW_W-1:0]   spi_row;
    logic [SLICE_W-1:0] spi_slice;
    logic               spi_bank_oob;
    logic               spi_conflict;
    logic               spi_fire;
    logic [WORD_W-1:0]  spi_wdata;
    logic [WORD_W-1:0]  spi_wmask;

    logic [NUM_BANKS-1:0] bank_en;
    logic [NUM_BANKS-1:0] bank_we;
    logic [ROW_W-1:0]     bank_addr  [NUM_BANKS];
    logic [WORD_W-1:0]    bank_wdata [NUM_BANKS];
    logic [WORD_W-1:0]    bank_wmask [NUM_BANKS];
    logic [WORD_W-1:0]    bank_rdata [NUM_BANKS];

    logic                 ctrl_read_valid_q, ctrl_read_valid_d;
    logic [BANK_W-1:0]    ctrl_rd_bank_q, ctrl_rd_bank_d;
    logic [WORD_W-1:0]    ctrl_hold_q, ctrl_hold_d;
    logic [WORD_W-1:0]    ctrl_sel_word;

    logic                 spi_rsp_valid_q, spi_rsp_valid_d;
    logic [BANK_W-1:0]    spi_rsp_bank_q, spi_rsp_bank_d;
    logic [SLICE_W-1:0]   spi_rsp_slice_q, spi_rsp_slice_d;
    logic                 spi_rsp_oob_q, spi_rsp_oob_d;
    logic [MSG_W-1:0]     spi_hold_q, spi_hold_d;
    logic [WORD_W-1:0]    spi_sel_word;
    logic [MSG_W-1:0]     spi_sel_slice;

    // Rotation: the write bank is always the one after the read bank, and a
    // swap promotes the write bank to read bank.
    always_comb begin
        wr_ptr   = (rd_ptr_q == BANK_W'(NUM_BANKS - 1)) ? '0 : rd_ptr_q + 1'b1;
        rd_ptr_d = (layer_swap && !global_power_down) ? wr_ptr : rd_ptr_q;
    end

    // SPI address decode and the slice-wide write pattern. Out-of-range bank
    // indices match no bank, so writes vanish and reads answer zero.
    always_comb begin
        spi_bank     = BANK_W'(addr_bank(64'(spi_address), SLICE_W, ROW_W, BANK_W));
        spi_row      = ROW_W'(addr_row(64'(spi_address), SLICE_W, ROW_W));
        spi_slice    = (SLICES == 1) ? '0
                                     : SLICE_W'(addr_slice(64'(spi_address), SLICE_W));
        spi_bank_oob = int'(spi_bank) >= NUM_BANKS;
        spi_wdata    = {SLICES{spi_data_in}};
        spi_wmask    = '0;
        for (int s = 0; s < SLICES; s++) begin
            if (spi_slice == SLICE_W'(s)) begin
                spi_wmask[s*MSG_W +: MSG_W] = '1;
            end
        end
        spi_conflict  = (ctrl_read_enable  && (spi_bank == rd_ptr_q)) ||
                        (ctrl_write_enable && (spi_bank == wr_ptr));
        spi_req_ready = !global_power_down && !spi_conflict;
        spi_fire      = spi_req_valid && spi_req_ready;
    end

    // Per-bank arbitration: control read, then control write, then SPI.
    // Control read and write never share a bank, so only SPI ever loses.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en[b]    = 1'b0;
            bank_we[b]    = 1'b0;
            bank_addr[b]  = '0;
            bank_wdata[b] = '0;
            bank_wmask[b] = '0;
            if (!global_power_down) begin
                if (ctrl_read_enable && (rd_ptr_q == BANK_W'(b))) begin
                    bank_en[b]   = 1'b1;
                    bank_addr[b] = ctrl_read_address;
                end else if (ctrl_write_enable && (wr_ptr == BANK_W'(b))) begin
                    bank_en[b]    = 1'b1;
                    bank_we[b]    = 1'b1;
                    bank_addr[b]  = ctrl_write_address;
                    bank_wdata[b] = ctrl_data_in;
                    bank_wmask[b] = ctrl_mask;
                end else if (spi_fire && (spi_bank == BANK_W'(b))) begin
                    bank_en[b]    = 1'b1;
                    bank_we[b]    = spi_write;
                    bank_addr[b]  = spi_row;
                    bank_wdata[b] = spi_wdata;
                    bank_wmask[b] = spi_wmask;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        activation_bank #(
            .WORD_W (WORD_W),
            .ROWS   (ACTIVATION_ROWS)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .power_down (global_power_down),
            .en         (bank_en[g]),
            .we         (bank_we[g]),
            .addr       (bank_addr[g]),
            .wdata      (bank_wdata[g]),
            .wmask      (bank_wmask[g]),
            .rdata      (bank_rdata[g])
        );
    end

    // Response bookkeeping: remember which bank/slice each read targeted so
    // the bank's registered output can be steered the following cycle.
    always_comb begin
        ctrl_read_valid_d = ctrl_read_enable && !global_power_down;
        ctrl_rd_bank_d    = ctrl_read_valid_d ? rd_ptr_q : ctrl_rd_bank_q;
        spi_rsp_valid_d   = spi_fire && !spi_write;
        spi_rsp_bank_d    = spi_rsp_valid_d ? spi_bank     : spi_rsp_bank_q;
        spi_rsp_slice_d   = spi_rsp_valid_d ? spi_slice    : spi_rsp_slice_q;
        spi_rsp_oob_d     = spi_rsp_valid_d ? spi_bank_oob : spi_rsp_oob_q;
    end

    // Output steering. Outputs show fresh bank data while valid and a held
    // copy otherwise, since a bank's read register may be reused by the
    // other requester in later cycles.
    always_comb begin
        ctrl_sel_word = '0;
        spi_sel_word  = '0;
        spi_sel_slice = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (ctrl_rd_bank_q == BANK_W'(b)) begin
                ctrl_sel_word = bank_rdata[b];
            end
            if (spi_rsp_bank_q == BANK_W'(b)) begin
                spi_sel_word = bank_rdata[b];
            end
        end
        for (int s = 0; s < SLICES; s++) begin
            if (spi_rsp_slice_q == SLICE_W'(s)) begin
                spi_sel_slice = spi_sel_word[s*MSG_W +: MSG_W];
            end
        end
        if (spi_rsp_oob_q) begin
            spi_sel_slice = '0;
        end
        ctrl_data_out = ctrl_read_valid_q ? ctrl_sel_word : ctrl_hold_q;
        spi_data_out  = spi_rsp_valid_q   ? spi_sel_slice : spi_hold_q;
        ctrl_hold_d   = ctrl_data_out;
        spi_hold_d    = spi_data_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q          <= '0;
            ctrl_read_valid_q <= 1'b0;
            ctrl_rd_bank_q    <= '0;
            ctrl_hold_q       <= '0;
            spi_rsp_valid_q   <= 1'b0;
            spi_rsp_bank_q    <= '0;
            spi_rsp_slice_q   <= '0;
            spi_rsp_oob_q     <= 1'b0;
            spi_hold_q        <= '0;
        end else begin
            rd_ptr_q          <= rd_ptr_d;
            ctrl_read_valid_q <= ctrl_read_valid_d;
            ctrl_rd_bank_q    <= ctrl_rd_bank_d;
            ctrl_hold_q       <= ctrl_hold_d;
            spi_rsp_valid_q   <= spi_rsp_valid_d;
            spi_rsp_bank_q    <= spi_rsp_bank_d;
            spi_rsp_slice_q   <= spi_rsp_slice_d;
            spi_rsp_oob_q     <= spi_rsp_oob_d;
            spi_hold_q        <= spi_hold_d;
        end
    end

    assign read_bank       = rd_ptr_q;
    assign write_bank      = wr_ptr;
    assign ctrl_read_valid = ctrl_read_valid_q;
    assign spi_rsp_valid   = spi_rsp_valid_q;

endmodule

// File: tb/tb_managed_activation_memory_banked.sv
// Directed bench for managed_activation_memory_banked built with three banks
// so the rotation wrap and an out-of-range SPI bank index (3) are reachable.
// SPI address layout here: {bank[7:6], row[5:1], slice[0]}.
module tb_managed_activation_memory_banked;

    localparam int WORD_W = 64;
    localparam int MSG_W  = 32;
    localparam int ROW_W  = 5;
    localparam int BANK_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              global_power_down;
    logic              spi_req_valid;
    logic              spi_req_ready;
    logic              spi_write;
    logic [13:0]       spi_address;
    logic [MSG_W-1:0]  spi_data_in;
    logic              spi_rsp_valid;
    logic [MSG_W-1:0]  spi_data_out;
    logic              ctrl_read_enable;
    logic [ROW_W-1:0]  ctrl_read_address;
    logic              ctrl_read_valid;
    logic [WORD_W-1:0] ctrl_data_out;
    logic              ctrl_write_enable;
    logic [ROW_W-1:0]  ctrl_write_address;
    logic [WORD_W-1:0] ctrl_data_in;
    logic [WORD_W-1:0] ctrl_mask;
    logic              layer_swap;
    logic [BANK_W-1:0] read_bank;
    logic [BANK_W-1:0] write_bank;

    int tests_run    = 0;
    int tests_failed = 0;

    managed_activation_memory_banked #(
        .ACTIVATION_WORD_BIT_WIDTH (WORD_W),
        .ACTIVATION_ROWS           (32),
        .NUM_BANKS                 (3),
        .START_ADDRESS_BIT_WIDTH   (14),
        .MESSAGE_BIT_WIDTH         (MSG_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .global_power_down  (global_power_down),
        .spi_req_valid      (spi_req_valid),
        .spi_req_ready      (spi_req_ready),
        .spi_write          (spi_write),
        .spi_address        (spi_address),
        .spi_data_in        (spi_data_in),
        .spi_rsp_valid      (spi_rsp_valid),
        .spi_data_out       (spi_data_out),
        .ctrl_read_enable   (ctrl_read_enable),
        .ctrl_read_address  (ctrl_read_address),
        .ctrl_read_valid    (ctrl_read_valid),
        .ctrl_data_out      (ctrl_data_out),
        .ctrl_write_enable  (ctrl_write_enable),
        .ctrl_write_address (ctrl_write_address),
        .ctrl_data_in       (ctrl_data_in),
        .ctrl_mask          (ctrl_mask),
        .layer_swap         (layer_swap),
        .read_bank          (read_bank),
        .write_bank         (write_bank)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an SPI request; {bank,row,slice} packed into the address.
    task automatic applyStimulus(input logic valid, input logic wr,
                                 input int bank, input int row, input int slice,
                                 input logic [MSG_W-1:0] data);
        spi_req_valid = valid;
        spi_write     = wr;
        spi_address   = 14'((bank << 6) | (row << 1) | slice);
        spi_data_in   = data;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        global_power_down = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
        ctrl_read_enable = 1'b0;
        ctrl_read_address = '0;
        ctrl_write_enable = 1'b0;
        ctrl_write_address = '0;
        ctrl_data_in = '0;
        ctrl_mask = '0;
        layer_swap = 1'b0;

        // ---- Reset state ----
        tick();
        tick();
        checkOutput("rst_read_bank", 64'(read_bank), 64'd0);
        checkOutput("rst_write_bank", 64'(write_bank), 64'd1);
        checkOutput("rst_ctrl_valid", 64'(ctrl_read_valid), 64'd0);
        checkOutput("rst_spi_valid", 64'(spi_rsp_valid), 64'd0);
        checkOutput("rst_ctrl_data", ctrl_data_out, 64'd0);
        checkOutput("rst_spi_data", 64'(spi_data_out), 64'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_read_bank", 64'(read_bank), 64'd0);
        checkOutput("idle_ctrl_valid", 64'(ctrl_read_valid), 64'd0);
        checkOutput("idle_spi_ready", 64'(spi_req_ready), 64'd1);

        // ---- Rotation with three banks: 1, 2, then wrap to 0 ----
        layer_swap = 1'b1;
        tick();
        checkOutput("swap1_read_bank", 64'(read_bank), 64'd1);
        checkOutput("swap1_write_bank", 64'(write_bank), 64'd2);
        tick();
        checkOutput("swap2_read_bank", 64'(read_bank), 64'd2);
        checkOutput("swap2_write_bank", 64'(write_bank), 64'd0);
        tick();
        checkOutput("swap3_read_bank", 64'(read_bank), 64'd0);
        checkOutput("swap3_write_bank", 64'(write_bank), 64'd1);
        layer_swap = 1'b0;

        // ---- Masked control write to bank 1 row 5, then read it back ----
        ctrl_write_enable = 1'b1;
        ctrl_write_address = 5'd5;
        ctrl_data_in = 64'h0;
        ctrl_mask = '1;
        tick();
        ctrl_data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        ctrl_mask = 64'h0000_0000_FFFF_FFFF;
        tick();
        ctrl_write_enable = 1'b0;
        layer_swap = 1'b1;
        tick();
        layer_swap = 1'b0;
        checkOutput("after_swap_read_bank", 64'(read_bank), 64'd1);
        ctrl_read_enable = 1'b1;
        ctrl_read_address = 5'd5;
        tick();
        ctrl_read_enable = 1'b0;
        checkOutput("masked_rd_valid", 64'(ctrl_read_valid), 64'd1);
        checkOutput("masked_rd_data", ctrl_data_out, 64'h0000_0000_FFFF_FFFF);
        tick();
        checkOutput("ctrl_valid_drop", 64'(ctrl_read_valid), 64'd0);
        checkOutput("ctrl_data_hold", ctrl_data_out, 64'h0000_0000_FFFF_FFFF);

        // ---- Write issued in the swap cycle lands in the pre-swap write bank (2) ----
        ctrl_write_enable = 1'b1;
        ctrl_write_address = 5'd6;
        ctrl_data_in = 64'h1111_2222_3333_4444;
        ctrl_mask = '1;
        layer_swap = 1'b1;
        tick();
        ctrl_write_enable = 1'b0;
        layer_swap = 1'b0;
        checkOutput("swapcyc_read_bank", 64'(read_bank), 64'd2);
        ctrl_read_enable = 1'b1;
        ctrl_read_address = 5'd6;
        tick();
        ctrl_read_enable = 1'b0;
        checkOutput("swapcyc_rd_data", ctrl_data_out, 64'h1111_2222_3333_4444);
        layer_swap = 1'b1;
        tick();
        layer_swap = 1'b0;
        checkOutput("back_to_bank0", 64'(read_bank), 64'd0);

        // ---- SPI slice writes to bank 0 row 3, then slice reads ----
        applyStimulus(1'b1, 1'b1, 0, 3, 0, 32'h1234_5678);
        #1;
        checkOutput("spi_wr0_ready", 64'(spi_req_ready), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 0, 3, 1, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b1, 1'b0, 0, 3, 1, '0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
        checkOutput("spi_rd1_valid", 64'(spi_rsp_valid), 64'd1);
        checkOutput("spi_rd1_data", 64'(spi_data_out), 64'hDEAD_BEEF);
        tick();
        checkOutput("spi_valid_pulse", 64'(spi_rsp_valid), 64'd0);
        checkOutput("spi_data_hold", 64'(spi_data_out), 64'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 0, 3, 0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
        checkOutput("spi_rd0_data", 64'(spi_data_out), 64'h1234_5678);
        ctrl_read_enable = 1'b1;
        ctrl_read_address = 5'd3;
        tick();
        ctrl_read_enable = 1'b0;
        checkOutput("row3_full_word", ctrl_data_out, 64'hDEAD_BEEF_1234_5678);

        // ---- SPI to bank 0 stalls while control reads bank 0 for 3 cycles ----
        applyStimulus(1'b1, 1'b0, 0, 3, 0, '0);
        ctrl_read_enable = 1'b1;
        ctrl_read_address = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("stall_ready_%0d", i), 64'(spi_req_ready), 64'd0);
            tick();
            checkOutput($sformatf("stall_no_rsp_%0d", i), 64'(spi_rsp_valid), 64'd0);
        end
        ctrl_read_enable = 1'b0;
        #1;
        checkOutput("stall_release_ready", 64'(spi_req_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
        checkOutput("stall_rsp_valid", 64'(spi_rsp_valid), 64'd1);
        checkOutput("stall_rsp_data", 64'(spi_data_out), 64'h1234_5678);

        // ---- SPI to bank 1 runs in parallel with a control read of bank 0 ----
        ctrl_read_enable = 1'b1;
        ctrl_read_address = 5'd3;
        applyStimulus(1'b1, 1'b0, 1, 5, 0, '0);
        #1;
        checkOutput("parallel_ready", 64'(spi_req_ready), 64'd1);
        tick();
        ctrl_read_enable = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
        checkOutput("parallel_spi_valid", 64'(spi_rsp_valid), 64'd1);
        checkOutput("parallel_spi_data", 64'(spi_data_out), 64'hFFFF_FFFF);
        checkOutput("parallel_ctrl_valid", 64'(ctrl_read_valid), 64'd1);
        checkOutput("parallel_ctrl_data", ctrl_data_out, 64'hDEAD_BEEF_1234_5678);

        // ---- Out-of-range bank 3: write dropped, read answers zero ----
        applyStimulus(1'b1, 1'b1, 3, 0, 0, 32'hCAFE_F00D);
        #1;
        checkOutput("oob_wr_ready", 64'(spi_req_ready), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 3, 0, 0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
        checkOutput("oob_rd_valid", 64'(spi_rsp_valid), 64'd1);
        checkOutput("oob_rd_data", 64'(spi_data_out), 64'd0);

        // ---- Power down blocks everything, then the pending request completes ----
        global_power_down = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, 3, 1, '0);
        ctrl_read_enable = 1'b1;
        ctrl_read_address = 5'd3;
        ctrl_write_enable = 1'b1;
        ctrl_write_address = 5'd5;
        ctrl_data_in = 64'h0;
        ctrl_mask = '1;
        layer_swap = 1'b1;
        #1;
        checkOutput("pd_ready", 64'(spi_req_ready), 64'd0);
        tick();
        checkOutput("pd_ctrl_valid", 64'(ctrl_read_valid), 64'd0);
        checkOutput("pd_spi_valid", 64'(spi_rsp_valid), 64'd0);
        checkOutput("pd_swap_ignored", 64'(read_bank), 64'd0);
        checkOutput("pd_ctrl_data_hold", ctrl_data_out, 64'hDEAD_BEEF_1234_5678);
        tick();
        checkOutput("pd_swap_ignored2", 64'(read_bank), 64'd0);
        global_power_down = 1'b0;
        ctrl_read_enable = 1'b0;
        ctrl_write_enable = 1'b0;
        layer_swap = 1'b0;
        #1;
        checkOutput("pd_exit_ready", 64'(spi_req_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
        checkOutput("pd_exit_rsp_valid", 64'(spi_rsp_valid), 64'd1);
        checkOutput("pd_exit_rsp_data", 64'(spi_data_out), 64'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 1, 5, 0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
        checkOutput("pd_mem_unchanged", 64'(spi_data_out), 64'hFFFF_FFFF);

        // ---- Reset right after an SPI read is accepted ----
        layer_swap = 1'b1;
        tick();
        layer_swap = 1'b0;
        checkOutput("prerst_read_bank", 64'(read_bank), 64'd1);
        applyStimulus(1'b1, 1'b0, 0, 3, 1, '0);
        #1;
        checkOutput("prerst_ready", 64'(spi_req_ready), 64'd1);
        tick();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
        #1;
        checkOutput("midrst_spi_valid", 64'(spi_rsp_valid), 64'd0);
        checkOutput("midrst_read_bank", 64'(read_bank), 64'd0);
        checkOutput("midrst_write_bank", 64'(write_bank), 64'd1);
        checkOutput("midrst_spi_data", 64'(spi_data_out), 64'd0);
        tick();
        checkOutput("midrst_spi_valid2", 64'(spi_rsp_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("postrst_spi_valid", 64'(spi_rsp_valid), 64'd0);
        checkOutput("postrst_read_bank", 64'(read_bank), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
